noc_traffic_gen: RTL
====================

# noc_traffic_gen

Per-node packet injector for the spidergon NoC. One instance per node replaces the static single-flit reset stimulus. Each instance emits complete multi-flit packets (head, body, tail) over a valid/ready handshake into its node's `data_input` slice. It offers selectable destination patterns, per-packet virtual-channel rotation, inter-packet gaps and a packet budget with a `done` flag.

## Interface
Parameters:
- `NUM_OF_NODES`, 8: node count; must be a power of two ≥ 2.
- `FLIT_DATA_WIDTH`, 16: payload bits; must be ≥ 2·`DEST_NODE_WIDTH` and ≥ 4.
- `NUM_OF_VIRTUAL_CHANNELS`, 2: VCs per port; must be a power of two ≥ 2.
- `NODE_ID`, 0: this node's address, 0..`NUM_OF_NODES`-1.
- `PACKET_LENGTH`, 4: flits per packet including head and tail. A value of 1 means a single header-only flit.
- `NUM_PACKETS`, 16: packet budget; 0 means unbounded.
- `GAP_CYCLES`, 2: idle cycles after each tail transfer.
- Derived: `DEST_NODE_WIDTH`=$clog2(`NUM_OF_NODES`); `VC_W`=$clog2(`NUM_OF_VIRTUAL_CHANNELS`); `FLIT_TOTAL_WIDTH`=2+`VC_W`+`FLIT_DATA_WIDTH`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: permits starting new packets.
- `mode` in 2: destination pattern. 00 = fixed, 01 = clockwise neighbour, 10 = across, 11 = random.
- `fixed_dest` in `DEST_NODE_WIDTH`: destination used in mode 00.
- `flit_out` out `FLIT_TOTAL_WIDTH`: {type[1:0], vc[`VC_W`-1:0], payload}.
- `flit_valid` out 1: `flit_out` is valid.
- `flit_ready` in 1: downstream accepts the flit.
- `packets_sent` out 16: completed packets; saturates at 16'hFFFF.
- `busy` out 1: a packet is in progress (HEAD/BODY/TAIL).
- `done` out 1: the packet budget is exhausted; sticky.

## Operation
- Flit types: 01 head, 10 body, 00 tail, 11 header-only (`PACKET_LENGTH`=1).
- Head and header-only payload: {dest, `NODE_ID`, zeros}, MSB-first.
- Body and tail payload: {seq[`FLIT_DATA_WIDTH`/2-1:0], idx[`FLIT_DATA_WIDTH`/2-1:0]}.
  - seq = `packets_sent` truncated.
  - idx = flit position within the packet; head is position 0.
- Destination is computed at head issue and held for the whole packet:
  - mode 00: `fixed_dest`.
  - mode 01: (`NODE_ID`+1) mod N.
  - mode 10: (`NODE_ID`+N/2) mod N.
  - mode 11: `lfsr`[`DEST_NODE_WIDTH`-1:0].
  - All wrap-around uses width truncation.
  - If the result equals `NODE_ID`, (`NODE_ID`+1) mod N is sent instead.
- VC: a counter starts at 0 and increments (mod VC count) after each completed packet. All flits of one packet carry the same VC.
- FSM states: IDLE, HEAD, BODY, TAIL, GAP, FIN.
  - IDLE → HEAD when `enable`=1 and the budget is not exhausted.
  - HEAD, on transfer: goes to BODY if `PACKET_LENGTH`>2, to TAIL if it equals 2, and is the packet end if it equals 1.
  - BODY stays in BODY until `PACKET_LENGTH`-2 body flits have transferred, then goes to TAIL.
  - At packet end: `packets_sent`+1 and VC advances.
  - After packet end, the next state is, in priority order:
    - FIN if the budget is reached;
    - else GAP if `GAP_CYCLES`>0;
    - else HEAD if `enable`=1;
    - else IDLE.
  - GAP counts `GAP_CYCLES` cycles, then goes to HEAD if `enable`=1, else IDLE.
  - FIN is absorbing until reset; `done`=1 in FIN.
- `enable` falling mid-packet does not truncate the packet; the current packet completes.
- `mode`/`fixed_dest` changes mid-packet are ignored.
- `reset` mid-packet abandons the packet immediately. No tail is sent.

## Timing
- Reset values:
  - `flit_valid`=0, `flit_out`=0, `packets_sent`=0, `busy`=0, `done`=0.
  - FSM = IDLE, VC counter = 0.
  - LFSR = 16'hACE1 ^ `NODE_ID` (never 0).
- All outputs are registered.
- `flit_valid` rises 1 cycle after `enable` is sampled high in IDLE.
- Handshake:
  - A transfer occurs on a cycle with `flit_valid`&&`flit_ready`.
  - While `flit_valid`=1 and `flit_ready`=0, `flit_out` holds stable.
  - `flit_valid` never drops without a transfer, except on reset.
- Throughput: with `flit_ready` held at 1, one flit per cycle, and back-to-back packets when `GAP_CYCLES`=0.
- Packet period with `flit_ready` held at 1 and `enable`=1: `PACKET_LENGTH`+`GAP_CYCLES` cycles.
- `packets_sent` updates the cycle after the tail/header-only transfer. `done` rises in the same cycle.
- `busy` is 1 from head issue until the cycle after the final transfer.

## Configuration
- `NOC_TRAFFIC_RANDOM_DEST_EN` defined:
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - The LFSR advances once per head/header-only transfer.
  - Mode 11 selects the random destination.
- Not defined:
  - No LFSR is built.
  - Mode 11 behaves exactly as mode 00.

## Test plan
- Fixed-mode packet: `NODE_ID`=1, mode 00, `fixed_dest`=0, `PACKET_LENGTH`=4, ready=1 → flits in order:
  - head {01, vc0, dest 0, src 1};
  - two body flits with idx 1, 2;
  - tail with idx 3.
  - Then 2 gap cycles, and `packets_sent`=1.
- Backpressure: `flit_ready` low for 5 cycles mid-body → `flit_out` stable throughout, no flit lost or duplicated, 4 flits total.
- Budget: `NUM_PACKETS`=3, `GAP_CYCLES`=0 → 12 consecutive valid cycles, VC sequence 0,1,0, then `done`=1 and `flit_valid`=0 forever.
- Pattern/self-avoid: `NODE_ID`=7, mode 01 → dest 0. Mode 10 → dest 3. Mode 00 with `fixed_dest`=7 → dest 0.
- Header-only and mid-packet reset: with `PACKET_LENGTH`=1, each flit is type 11. A reset asserted during BODY → `flit_valid`=0 next cycle and `packets_sent`=0.
- Random (`NOC_TRAFFIC_RANDOM_DEST_EN`): mode 11 over 64 packets → destinations match a reference LFSR model and never equal `NODE_ID`.

Source files
------------

// File: rtl/noc_traffic_gen.sv
// Per-node multi-flit packet injector with destination patterns, VC rotation, gaps and a packet budget.
// Define NOC_TRAFFIC_RANDOM_DEST_EN to build the LFSR that drives the random destination mode (11).
module noc_traffic_gen #(
    parameter int NUM_OF_NODES            = 8,
    parameter int FLIT_DATA_WIDTH         = 16,
    parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int NODE_ID                 = 0,
    parameter int PACKET_LENGTH           = 4,
    parameter int NUM_PACKETS             = 16,
    parameter int GAP_CYCLES              = 2,
    localparam int DEST_NODE_WIDTH  = $clog2(NUM_OF_NODES),
    localparam int VC_W             = $clog2(NUM_OF_VIRTUAL_CHANNELS),
    localparam int FLIT_TOTAL_WIDTH = 2 + VC_W + FLIT_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [1:0]                    mode,
    input  logic [DEST_NODE_WIDTH-1:0]    fixed_dest,
    output logic [FLIT_TOTAL_WIDTH-1:0]   flit_out,
    output logic                          flit_valid,
    input  logic                          flit_ready,
    output logic [15:0]                   packets_sent,
    output logic                          busy,
    output logic                          done
);

    localparam int DW  = DEST_NODE_WIDTH;
    localparam int FDW = FLIT_DATA_WIDTH;
    localparam int FTW = FLIT_TOTAL_WIDTH;
    localparam int HW  = FLIT_DATA_WIDTH / 2;

    localparam logic [DW-1:0] SELF_ID   = DW'(NODE_ID);
    localparam logic [DW-1:0] NEXT_ID   = DW'(NODE_ID + 1);
    localparam logic [DW-1:0] ACROSS_ID = DW'(NODE_ID + NUM_OF_NODES / 2);

    localparam logic [15:0] LAST_BODY_IDX = 16'(PACKET_LENGTH - 2);
    localparam logic [15:0] GAP_LAST      = 16'(GAP_CYCLES - 1);

    localparam logic [1:0] T_HEAD    = 2'b01;
    localparam logic [1:0] T_BODY    = 2'b10;
    localparam logic [1:0] T_TAIL    = 2'b00;
    localparam logic [1:0] T_HONLY   = 2'b11;
    localparam logic [1:0] HEAD_TYPE = (PACKET_LENGTH == 1) ? T_HONLY : T_HEAD;

    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL, S_GAP, S_FIN} state_t;

    state_t            state_q;
    logic [FTW-1:0]    flit_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic [15:0]       sent_q;
    logic [15:0]       idx_q;
    logic [15:0]       gap_q;
    logic [VC_W-1:0]   vc_q;

    logic              xfer;
    logic              head_xfer;
    logic              last_xfer;
    logic              budget_hit;
    logic              exhausted;
    logic              start_head;
    logic [DW-1:0]     pattern_d;
    logic [DW-1:0]     dest_d;
    logic [VC_W-1:0]   vc_d;
    logic [FDW-1:0]    head_pay_d;
    logic [FTW-1:0]    head_flit_d;
    logic [15:0]       sent_d;
    logic [15:0]       idx_d;

    function automatic logic [FTW-1:0] data_flit(input logic [1:0] t, input logic [VC_W-1:0] vc,
                                                 input logic [15:0] seq, input logic [15:0] idx);
        logic [HW-1:0] s;
        logic [HW-1:0] i;
        s = HW'(seq);
        i = HW'(idx);
        return {t, vc, FDW'({s, i})};
    endfunction

    assign xfer      = valid_q && flit_ready;
    assign head_xfer = xfer && (state_q == S_HEAD);
    assign last_xfer = xfer && ((state_q == S_TAIL) || (state_q == S_HEAD && PACKET_LENGTH == 1));

`ifdef NOC_TRAFFIC_RANDOM_DEST_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Galois step on every head transfer; the value already stepped this cycle seeds a head issued in the same cycle
    assign lfsr_d = head_xfer ? (lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1)) : lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1 ^ 16'(NODE_ID);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    always_comb begin
        pattern_d = fixed_dest;
        case (mode)
            2'b01:   pattern_d = NEXT_ID;
            2'b10:   pattern_d = ACROSS_ID;
`ifdef NOC_TRAFFIC_RANDOM_DEST_EN
            2'b11:   pattern_d = lfsr_d[DW-1:0];
`else
            2'b11:   pattern_d = fixed_dest;
`endif
            default: pattern_d = fixed_dest;
        endcase
    end

    assign dest_d      = (pattern_d == SELF_ID) ? NEXT_ID : pattern_d;
    assign vc_d        = last_xfer ? vc_q + VC_W'(1) : vc_q;
    assign head_pay_d  = (FDW'(dest_d) << (FDW - DW)) | (FDW'(SELF_ID) << (FDW - 2 * DW));
    assign head_flit_d = {HEAD_TYPE, vc_d, head_pay_d};
    assign sent_d      = (sent_q == 16'hFFFF) ? sent_q : sent_q + 16'd1;
    assign idx_d       = idx_q + 16'd1;
    assign budget_hit  = (NUM_PACKETS != 0) && (32'(sent_q) + 32'd1 >= 32'(NUM_PACKETS));
    assign exhausted   = (NUM_PACKETS != 0) && (32'(sent_q) >= 32'(NUM_PACKETS));

    // A new head may follow the tail directly only when no gap is configured
    assign start_head = enable && (((state_q == S_IDLE) && !exhausted) ||
                                   ((state_q == S_GAP) && (gap_q == GAP_LAST)) ||
                                   (last_xfer && !budget_hit && GAP_CYCLES == 0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            flit_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sent_q  <= 16'd0;
            idx_q   <= 16'd0;
            gap_q   <= 16'd0;
            vc_q    <= '0;
        end else begin
            if (last_xfer) begin
                sent_q  <= sent_d;
                vc_q    <= vc_d;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                if (budget_hit) begin
                    state_q <= S_FIN;
                    done_q  <= 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    state_q <= S_GAP;
                    gap_q   <= 16'd0;
                end else begin
                    state_q <= S_IDLE;
                end
            end else begin
                case (state_q)
                    S_HEAD: begin
                        if (xfer) begin
                            idx_q <= 16'd1;
                            if (PACKET_LENGTH == 2) begin
                                state_q <= S_TAIL;
                                flit_q  <= data_flit(T_TAIL, vc_q, sent_q, 16'd1);
                            end else begin
                                state_q <= S_BODY;
                                flit_q  <= data_flit(T_BODY, vc_q, sent_q, 16'd1);
                            end
                        end
                    end
                    S_BODY: begin
                        if (xfer) begin
                            idx_q <= idx_d;
                            if (idx_q == LAST_BODY_IDX) begin
                                state_q <= S_TAIL;
                                flit_q  <= data_flit(T_TAIL, vc_q, sent_q, idx_d);
                            end else begin
                                flit_q  <= data_flit(T_BODY, vc_q, sent_q, idx_d);
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_q == GAP_LAST) begin
                            state_q <= S_IDLE;
                        end else begin
                            gap_q <= gap_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
            if (start_head) begin
                state_q <= S_HEAD;
                flit_q  <= head_flit_d;
                valid_q <= 1'b1;
                busy_q  <= 1'b1;
            end
        end
    end

    assign flit_out     = flit_q;
    assign flit_valid   = valid_q;
    assign packets_sent = sent_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
